// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 8-bit combinational ALU: registers operands and
// opcode, waits a settle time, then captures result, flags and accumulator.
module alu_cmd_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [7:0]   cmd_a,
   input  logic [7:0]   cmd_b,
   input  logic         cmd_use_acc,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [3:0]   alu_sel,
   input  logic [7:0]   alu_out,
   input  logic [3:0]   alu_flag,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [7:0]   res_data,
   output logic [3:0]   res_flag,
   output logic         res_err,
   output logic [7:0]   acc_value
);

   // Handshakes: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both 1; a result transfers where res_valid and res_ready
   // are both 1. Payloads are only meaningful while the matching valid is 1.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       OP_DIV    = 4'h3;
   localparam logic [3:0]       OP_MAX    = 4'hB;
   localparam logic [3:0]       SEL_INERT = 4'hF;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       alu_a_q, alu_a_d;
   logic [7:0]       alu_b_q, alu_b_d;
   logic [3:0]       alu_sel_q, alu_sel_d;
   logic [7:0]       res_data_q, res_data_d;
   logic [3:0]       res_flag_q, res_flag_d;
   logic             res_err_q, res_err_d;
   logic [7:0]       acc_q, acc_d;
   logic             err_pend_q, err_pend_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             res_valid_q, res_valid_d;

   logic             cmd_accept;
   logic             op_legal;
   logic             settle_done;
   logic [7:0]       eff_a;

   // The ALU's own zero flag is not trusted; zero is derived locally.
   logic             unused_alu_zero;
   assign unused_alu_zero = alu_flag[0];

   always_comb begin
      eff_a       = cmd_use_acc ? acc_q : cmd_a;
      op_legal    = (cmd_op <= OP_MAX) && !((cmd_op == OP_DIV) && (cmd_b == 8'h00));
      cmd_accept  = (state_q == IDLE) && cmd_valid;
      settle_done = (state_q == SETTLE) && (err_pend_q || (cnt_q == CNT_LAST));
   end

   // State register and all datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         alu_a_q     <= 8'h00;
         alu_b_q     <= 8'h00;
         alu_sel_q   <= SEL_INERT;
         res_data_q  <= 8'h00;
         res_flag_q  <= 4'h0;
         res_err_q   <= 1'b0;
         acc_q       <= 8'h00;
         err_pend_q  <= 1'b0;
         cmd_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         res_data_q  <= res_data_d;
         res_flag_q  <= res_flag_d;
         res_err_q   <= res_err_d;
         acc_q       <= acc_d;
         err_pend_q  <= err_pend_d;
         cmd_ready_q <= cmd_ready_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cmd_accept)  state_d = SETTLE;
         SETTLE:  if (settle_done) state_d = HOLD;
         HOLD:    if (res_ready)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output-register next values.
   always_comb begin
      cnt_d      = cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      res_data_d = res_data_q;
      res_flag_d = res_flag_q;
      res_err_d  = res_err_q;
      acc_d      = acc_q;
      err_pend_d = err_pend_q;

      if (cmd_accept) begin
         cnt_d      = '0;
         err_pend_d = !op_legal;
         if (op_legal) begin
            alu_a_d   = eff_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_op;
         end
      end

      if (state_q == SETTLE) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (settle_done) begin
            // A rejected command spends one cycle here so both paths share
            // the same capture point; its ALU inputs were never touched.
            if (err_pend_q) begin
               res_data_d = 8'h00;
               res_flag_d = 4'h0;
               res_err_d  = 1'b1;
            end else begin
               res_data_d = alu_out;
               res_flag_d = {alu_flag[3:1], (alu_out == 8'h00)};
               res_err_d  = 1'b0;
               acc_d      = alu_out;
            end
            err_pend_d = 1'b0;
         end
      end

      cmd_ready_d = (state_d == IDLE);
      res_valid_d = (state_d == HOLD);
   end

   assign cmd_ready = cmd_ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_flag  = res_flag_q;
   assign res_err   = res_err_q;
   assign acc_value = acc_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 and 3) driven by an ALU
// stub, checked every cycle against a transaction-level model plus literals.
module tb_alu_cmd_sequencer;

   localparam int SET0 = 1;
   localparam int SET1 = 3;

   logic clk;
   logic rst;

   logic       cmd_valid   [2];
   logic       cmd_ready   [2];
   logic [3:0] cmd_op      [2];
   logic [7:0] cmd_a       [2];
   logic [7:0] cmd_b       [2];
   logic       cmd_use_acc [2];
   logic [7:0] alu_a       [2];
   logic [7:0] alu_b       [2];
   logic [3:0] alu_sel     [2];
   logic [7:0] alu_out     [2];
   logic [3:0] alu_flag    [2];
   logic       res_valid   [2];
   logic       res_ready   [2];
   logic [7:0] res_data    [2];
   logic [3:0] res_flag    [2];
   logic       res_err     [2];
   logic [7:0] acc_value   [2];

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ALU stub ----------------
   // Returns {out[7:0], flag[3:0]}; flag[0] is forced high so a sequencer
   // that forwards it instead of computing zero is caught.
   function automatic logic [11:0] alu_fn(logic [3:0] sel, logic [7:0] a, logic [7:0] b);
      logic [15:0] w;
      logic [7:0]  o;
      logic [3:0]  f;
      o = 8'h00;
      f = 4'b0001;
      w = 16'h0;
      case (sel)
         4'h0: begin w = 16'(a) + 16'(b); o = w[7:0]; f[1] = w[8]; end
         4'h1: begin o = a - b; f[3] = (a < b); end
         4'h2: begin w = 16'(a) * 16'(b); o = w[7:0]; f[2] = (w > 16'd255); end
         4'h3: o = (b != 8'h00) ? a / b : 8'h00;
         4'h4: begin o = a << 1; f[1] = a[7]; end
         4'h5: o = a >> 1;
         4'h6: o = a & b;
         4'h7: o = a | b;
         4'h8: o = a ^ b;
         4'h9: o = ~(a ^ b);
         4'hA: o = ~(a & b);
         4'hB: o = ~(a | b);
         default: o = 8'h00;
      endcase
      return {o, f};
   endfunction

   assign {alu_out[0], alu_flag[0]} = alu_fn(alu_sel[0], alu_a[0], alu_b[0]);
   assign {alu_out[1], alu_flag[1]} = alu_fn(alu_sel[1], alu_a[1], alu_b[1]);

   alu_cmd_sequencer #(.SETTLE_CYCLES(SET0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
      .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_use_acc(cmd_use_acc[0]),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
      .alu_out(alu_out[0]), .alu_flag(alu_flag[0]),
      .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
      .res_flag(res_flag[0]), .res_err(res_err[0]), .acc_value(acc_value[0])
   );

   alu_cmd_sequencer #(.SETTLE_CYCLES(SET1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
      .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_use_acc(cmd_use_acc[1]),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
      .alu_out(alu_out[1]), .alu_flag(alu_flag[1]),
      .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
      .res_flag(res_flag[1]), .res_err(res_err[1]), .acc_value(acc_value[1])
   );

   // ---------------- comparison helper ----------------
   task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] actual=%h required=%h at %0t", name, inst, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   // A command is accepted when idle, its result appears after a fixed wait
   // (settle time, or one cycle if rejected), and is held until consumed.
   logic       m_ready [2];
   logic       m_valid [2];
   int         m_wait  [2];
   logic [7:0] m_data  [2];
   logic [3:0] m_flag  [2];
   logic       m_err   [2];
   logic [7:0] m_acc   [2];
   logic [7:0] m_a     [2];
   logic [7:0] m_b     [2];
   logic [3:0] m_sel   [2];
   logic [7:0] p_data  [2];
   logic [3:0] p_flag  [2];
   logic       p_err   [2];
   logic [7:0] p_acc   [2];

   function automatic int settle_of(int i);
      return (i == 0) ? SET0 : SET1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_ready[i] = 1'b1; m_valid[i] = 1'b0; m_wait[i] = 0;
            m_data[i] = 8'h00; m_flag[i] = 4'h0; m_err[i] = 1'b0; m_acc[i] = 8'h00;
            m_a[i] = 8'h00; m_b[i] = 8'h00; m_sel[i] = 4'hF;
            p_data[i] = 8'h00; p_flag[i] = 4'h0; p_err[i] = 1'b0; p_acc[i] = 8'h00;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_ready[i]) begin
               if (cmd_valid[i]) begin
                  logic [7:0]  ea;
                  logic [11:0] r;
                  m_ready[i] = 1'b0;
                  ea = cmd_use_acc[i] ? m_acc[i] : cmd_a[i];
                  if (cmd_op[i] > 4'hB || (cmd_op[i] == 4'h3 && cmd_b[i] == 8'h00)) begin
                     p_data[i] = 8'h00; p_flag[i] = 4'h0; p_err[i] = 1'b1; p_acc[i] = m_acc[i];
                     m_wait[i] = 1;
                  end else begin
                     m_a[i] = ea; m_b[i] = cmd_b[i]; m_sel[i] = cmd_op[i];
                     r = alu_fn(cmd_op[i], ea, cmd_b[i]);
                     p_data[i] = r[11:4];
                     p_flag[i] = {r[3:1], (r[11:4] == 8'h00)};
                     p_err[i]  = 1'b0;
                     p_acc[i]  = r[11:4];
                     m_wait[i] = settle_of(i);
                  end
               end
            end else if (m_wait[i] > 0) begin
               m_wait[i]--;
               if (m_wait[i] == 0) begin
                  m_valid[i] = 1'b1;
                  m_data[i] = p_data[i]; m_flag[i] = p_flag[i];
                  m_err[i] = p_err[i]; m_acc[i] = p_acc[i];
               end
            end else if (m_valid[i] && res_ready[i]) begin
               m_valid[i] = 1'b0;
               m_ready[i] = 1'b1;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("cmd_ready", i, 8'(cmd_ready[i]), 8'(m_ready[i]));
         chk("res_valid", i, 8'(res_valid[i]), 8'(m_valid[i]));
         chk("res_data",  i, res_data[i], m_data[i]);
         chk("res_flag",  i, 8'(res_flag[i]), 8'(m_flag[i]));
         chk("res_err",   i, 8'(res_err[i]), 8'(m_err[i]));
         chk("acc_value", i, acc_value[i], m_acc[i]);
         chk("alu_a",     i, alu_a[i], m_a[i]);
         chk("alu_b",     i, alu_b[i], m_b[i]);
         chk("alu_sel",   i, 8'(alu_sel[i]), 8'(m_sel[i]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int i, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic use_acc);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout[%0d] actual=busy required=ready", i);
      end
      cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; cmd_use_acc[i] = use_acc;
      @(posedge clk);
      @(negedge clk);
      cmd_valid[i] = 1'b0;
      cmd_op[i] = 4'($urandom_range(0, 15));
      cmd_a[i]  = 8'($urandom_range(0, 255));
      cmd_b[i]  = 8'($urandom_range(0, 255));
   endtask

   // Counts edges from the accept edge until res_valid is seen.
   task automatic wait_result(input int i, output int lat);
      lat = 0;
      if (res_valid[i]) lat = 1;
      while (!res_valid[i] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!res_valid[i]) begin
         n_cmp++; n_bad++;
         $display("FAIL result_timeout[%0d] actual=no_valid required=valid", i);
      end
   endtask

   task automatic take(input int i);
      res_ready[i] = 1'b1;
      @(negedge clk);
      res_ready[i] = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int lat;
      for (int i = 0; i < 2; i++) begin
         cmd_valid[i] = 1'b0; cmd_op[i] = 4'h0; cmd_a[i] = 8'h00; cmd_b[i] = 8'h00;
         cmd_use_acc[i] = 1'b0; res_ready[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", 0, 8'(cmd_ready[0]), 8'h01);
      chk("rst_res_valid", 0, 8'(res_valid[0]), 8'h00);
      chk("rst_alu_sel",   0, 8'(alu_sel[0]), 8'h0F);
      chk("rst_acc",       0, acc_value[0], 8'h00);
      rst = 1'b0;

      // Add with carry; first-result latency.
      // The accept edge falls inside send; the first negedge after it is
      // handled by wait_result, so a settle-1 result reads latency 1.
      cmd_valid[0] = 1'b0;
      send(0, 4'h0, 8'hC8, 8'h64, 1'b0);
      wait_result(0, lat);
      chk("add_latency", 0, 8'(lat), 8'd1);
      chk("add_data", 0, res_data[0], 8'h2C);
      chk("add_flag", 0, 8'(res_flag[0]), 8'h02);
      chk("add_err",  0, 8'(res_err[0]), 8'h00);
      chk("add_acc",  0, acc_value[0], 8'h2C);
      take(0);

      // Zero result, then chained OR from the accumulator.
      send(0, 4'h1, 8'h05, 8'h05, 1'b0);
      wait_result(0, lat);
      chk("sub_data", 0, res_data[0], 8'h00);
      chk("sub_flag", 0, 8'(res_flag[0]), 8'h01);
      take(0);
      send(0, 4'h7, 8'hAA, 8'h03, 1'b1);
      wait_result(0, lat);
      chk("or_alu_a", 0, alu_a[0], 8'h00);
      chk("or_data",  0, res_data[0], 8'h03);
      chk("or_flag",  0, 8'(res_flag[0]), 8'h00);
      take(0);

      // Multiply overflow.
      send(0, 4'h2, 8'h14, 8'h14, 1'b0);
      wait_result(0, lat);
      chk("mul_data", 0, res_data[0], 8'h90);
      chk("mul_flag", 0, 8'(res_flag[0]), 8'h04);
      take(0);

      // Rejected commands: divide by zero and an undefined opcode.
      send(0, 4'h3, 8'h07, 8'h00, 1'b0);
      wait_result(0, lat);
      chk("div0_latency", 0, 8'(lat), 8'd1);
      chk("div0_err",  0, 8'(res_err[0]), 8'h01);
      chk("div0_data", 0, res_data[0], 8'h00);
      chk("div0_acc",  0, acc_value[0], 8'h90);
      chk("div0_sel",  0, 8'(alu_sel[0]), 8'h02);
      take(0);
      send(0, 4'hC, 8'h11, 8'h22, 1'b0);
      wait_result(0, lat);
      chk("opc_latency", 0, 8'(lat), 8'd1);
      chk("opc_err",  0, 8'(res_err[0]), 8'h01);
      chk("opc_acc",  0, acc_value[0], 8'h90);
      chk("opc_sel",  0, 8'(alu_sel[0]), 8'h02);
      take(0);

      // Backpressure with an ignored command pulse.
      send(0, 4'h8, 8'h0F, 8'hF0, 1'b0);
      wait_result(0, lat);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 0, 8'(res_valid[0]), 8'h01);
         chk("bp_data",  0, res_data[0], 8'hFF);
         chk("bp_ready", 0, 8'(cmd_ready[0]), 8'h00);
         cmd_valid[0] = (c == 2); cmd_op[0] = 4'h0; cmd_a[0] = 8'h01; cmd_b[0] = 8'h01;
         @(negedge clk);
      end
      cmd_valid[0] = 1'b0;
      chk("bp_acc", 0, acc_value[0], 8'hFF);
      take(0);
      chk("bp_ready_back", 0, 8'(cmd_ready[0]), 8'h01);
      chk("bp_valid_drop", 0, 8'(res_valid[0]), 8'h00);

      // Settle-3 latency, then reset in the middle of settling.
      send(1, 4'h0, 8'h01, 8'h02, 1'b0);
      wait_result(1, lat);
      chk("s3_latency", 1, 8'(lat), 8'd3);
      chk("s3_data", 1, res_data[1], 8'h03);
      take(1);
      send(1, 4'h0, 8'h03, 8'h04, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 1, 8'(res_valid[1]), 8'h00);
      chk("mid_rst_acc",   1, acc_value[1], 8'h00);
      chk("mid_rst_sel",   1, 8'(alu_sel[1]), 8'h0F);
      chk("mid_rst_ready", 1, 8'(cmd_ready[1]), 8'h01);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_no_result", 1, 8'(res_valid[1]), 8'h00);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side driver for the 8-bit combinational ALU: accepts opcode/operand commands over a valid/ready handshake and drives the ALU's A, B and Sel inputs from registers.
- Waits a fixed settle time, then captures Out/Flag into result registers.
- Keeps a running 8-bit accumulator for chained calculator operations.
- Sits between the calculator front end (keypad/command decode) and the ALU.

Parameters:
- SETTLE_CYCLES, 1, clock cycles the ALU inputs are held stable before capture (legal range 1..15).
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr, 6 AND, 7 OR, 8 XOR, 9 XNOR, A NAND, B NOR.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_use_acc  input  1  1 = use the accumulator instead of cmd_a as operand A.
- alu_a  output  8  registered ALU A input.
- alu_b  output  8  registered ALU B input.
- alu_sel  output  4  registered ALU Sel input.
- alu_out  input  8  ALU result.
- alu_flag  input  4  ALU flags: [1] carry, [2] overflow, [3] underflow.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_data  output  8  captured result.
- res_flag  output  4  [0] zero, [1] carry, [2] overflow, [3] underflow.
- res_err  output  1  command rejected (illegal opcode or divide by zero).
- acc_value  output  8  current accumulator value.

Behaviour:
- Reset values (async, immediate): state IDLE, cmd_ready 1, res_valid 0, res_data 0, res_flag 0, res_err 0, acc_value 0, alu_a 0, alu_b 0, alu_sel 4'hF (inert ALU default), settle counter 0.
- States: IDLE, SETTLE, HOLD.
- cmd_ready is 1 only in IDLE; it is a registered state decode with no combinational path from any input.
- Command acceptance in IDLE, when cmd_valid=1:
  - effective A = cmd_use_acc ? acc_value : cmd_a.
  - Legal command (op ≤ 4'hB, and not op=3 with cmd_b=0): load alu_a, alu_b, alu_sel; counter=0; go to SETTLE.
  - Illegal command: alu_* unchanged; go to HOLD with res_data=0, res_flag=0, res_err=1; acc unchanged.
- SETTLE:
  - Counter increments each cycle; alu_a, alu_b and alu_sel stay constant.
  - On the edge where counter == SETTLE_CYCLES-1: capture res_data=alu_out, res_flag[3:1]=alu_flag[3:1], res_flag[0]=(alu_out==8'h00), res_err=0, acc_value=alu_out; go to HOLD.
  - res_flag[0] is computed locally for every legal op, including logic ops; ALU Flag[0] is ignored.
- Latency: command accepted at edge k gives res_valid=1 after edge k+SETTLE_CYCLES. An illegal command gives res_valid=1 after edge k+1.
- HOLD:
  - res_valid=1; res_data, res_flag and res_err are stable.
  - res_ready=1 moves the state to IDLE at the next edge, and res_valid drops at that edge.
  - Results are never overwritten or dropped under backpressure.
- Throughput: one command per SETTLE_CYCLES+2 cycles at best. A new command cannot be accepted in the same cycle a result is consumed.
- Outside HOLD, res_* hold their last values; res_valid alone qualifies them.
- Arithmetic width: all ALU results are 8-bit truncated as produced by the ALU; the sequencer does no extension.
- Reset mid-operation (SETTLE or HOLD): immediate return to IDLE with reset values; any pending result is lost and the accumulator is cleared.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- Add 200+100 (0xC8+0x64), SETTLE_CYCLES=1 → res_data=0x2C, res_flag=4'b0010, res_err=0, acc=0x2C, res_valid exactly 1 cycle after accept.
- Sub 5-5, then OR with use_acc=1, cmd_b=0x03 → first res 0x00 with flag 4'b0001; second res 0x03 with flag 4'b0000; alu_a driven as 0x00 on the second op.
- Mul 20*20 (0x14*0x14) → res_data=0x90, res_flag[2]=1, res_flag[0]=0.
- Div 7/0 and opcode 4'hC → each gives res_err=1, res_data=0, acc unchanged, alu_sel unchanged, res_valid after 1 cycle.
- Hold res_ready=0 for 5 cycles after a result → res_valid, res_data and res_flag stable; cmd_ready=0; a cmd_valid pulse is ignored; after res_ready=1, cmd_ready returns 1 next cycle.
- Assert rst during SETTLE with SETTLE_CYCLES=3 → immediate IDLE, res_valid=0, acc=0, alu_sel=4'hF; no result is emitted after rst deasserts.
